// File: rtl/led_display_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_display_sched_pkg
//  Purpose  : Shared state encodings and LED constants for the front-panel
//             display scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package led_display_sched_pkg;

    // Display owner; also driven out as the mode code
    localparam logic [1:0] c_ST_CYLON = 2'd0;
    localparam logic [1:0] c_ST_ERR   = 2'd1;
    localparam logic [1:0] c_ST_STAT  = 2'd2;
    localparam logic [1:0] c_ST_OFF   = 2'd3;

    localparam logic [11:0] c_LED_ALL_ON  = 12'hFFF;
    localparam logic [11:0] c_LED_ALL_OFF = 12'h000;

endpackage
`default_nettype wire

// File: rtl/led_display_sched_tick.sv
`default_nettype none
// ============================================================================
//  Module   : led_tick
//  Purpose  : Free-running prescaler; tick is high for one clock every
//             2^MXPRE clocks. A synchronous clear restarts the period.
//  Revision : 1.0 - initial release
// ============================================================================
module led_tick #(
    parameter int MXPRE = 21
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam logic [MXPRE-1:0] c_ONE = 1;

    logic [MXPRE-1:0] r_count;

    // Count every clock; reset or clear restarts the tick period
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_ONE;
        end
    end

    assign tick = &r_count;

endmodule
`default_nettype wire

// File: rtl/led_display_sched.sv
`default_nettype none
// ============================================================================
//  Module   : led_display_sched
//  Purpose  : Shares the 12-LED panel between the cylon generator, an error
//             flash sequence and a timed status word.
//             Priority: OFF > error > status > cylon.
//  Revision : 1.0 - initial release
// ============================================================================
module led_display_sched
    import led_display_sched_pkg::*;
#(
    parameter int MXPRE      = 21,
    parameter int FLASH_CNT  = 4,
    parameter int HOLD_TICKS = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cfg_enable,
    input  logic [1:0]  cfg_rate,
    output logic [1:0]  cylon_rate,
    input  logic [11:0] cylon_q,
    input  logic        err_req,
    input  logic        stat_req,
    input  logic [11:0] stat_data,
    output logic        stat_ack,
    output logic [11:0] led,
    output logic [1:0]  mode
);

    localparam int c_FW = $clog2(2 * FLASH_CNT);
    localparam int c_HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [c_FW-1:0] c_FLASH_LAST = c_FW'(2 * FLASH_CNT - 1);
    localparam logic [c_FW-1:0] c_FLASH_ONE  = 1;
    localparam logic [c_HW-1:0] c_HOLD_LAST  = c_HW'(HOLD_TICKS - 1);
    localparam logic [c_HW-1:0] c_HOLD_ONE   = 1;

    logic [1:0]      r_state;
    logic            r_err_pend;
    logic            r_phase;
    logic [c_FW-1:0] r_flash_cnt;
    logic [c_HW-1:0] r_hold_cnt;
    logic [11:0]     r_stat_reg;
    logic [11:0]     r_led;
    logic            r_stat_ack;

    logic [1:0]      w_next_state;
    logic            w_next_phase;
    logic [c_FW-1:0] w_next_flash;
    logic [c_HW-1:0] w_next_hold;
    logic [11:0]     w_next_stat;
    logic            w_ack;
    logic            w_restart;
    logic            w_clear;
    logic            w_tick;
    logic [11:0]     w_led_mux;

    assign cylon_rate = cfg_rate;
    assign stat_ack   = r_stat_ack;
    assign led        = r_led;
    assign mode       = r_state;

    // Every state change (and an error restart) begins a fresh tick period
    assign w_clear = (w_next_state != r_state) || w_restart;

    led_tick #(
        .MXPRE (MXPRE)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .clear (w_clear),
        .tick  (w_tick)
    );

    // Next-state and next-counter resolution in priority order
    always_comb begin
        w_next_state = r_state;
        w_next_phase = r_phase;
        w_next_flash = r_flash_cnt;
        w_next_hold  = r_hold_cnt;
        w_next_stat  = r_stat_reg;
        w_ack        = 1'b0;
        w_restart    = 1'b0;
        if (!cfg_enable) begin
            w_next_state = c_ST_OFF;
        end else begin
            case (r_state)
                c_ST_OFF: begin
                    w_next_state = c_ST_CYLON;
                end
                c_ST_CYLON: begin
                    if (r_err_pend) begin
                        w_next_state = c_ST_ERR;
                        w_next_phase = 1'b1;
                        w_next_flash = '0;
                    end else if (stat_req && !err_req) begin
                        // An error arriving this cycle outranks the status
                        // request, so hold off the ack until it has run
                        w_next_state = c_ST_STAT;
                        w_next_hold  = '0;
                        w_next_stat  = stat_data;
                        w_ack        = 1'b1;
                    end
                end
                c_ST_STAT: begin
                    if (r_err_pend) begin
                        w_next_state = c_ST_ERR;
                        w_next_phase = 1'b1;
                        w_next_flash = '0;
                    end else if (w_tick) begin
                        if (r_hold_cnt == c_HOLD_LAST) begin
                            w_next_state = c_ST_CYLON;
                        end else begin
                            w_next_hold = r_hold_cnt + c_HOLD_ONE;
                        end
                    end
                end
                default: begin // c_ST_ERR
                    if (err_req) begin
                        w_restart    = 1'b1;
                        w_next_phase = 1'b1;
                        w_next_flash = '0;
                    end else if (w_tick) begin
                        if (r_flash_cnt == c_FLASH_LAST) begin
                            w_next_state = c_ST_CYLON;
                        end else begin
                            w_next_phase = ~r_phase;
                            w_next_flash = r_flash_cnt + c_FLASH_ONE;
                        end
                    end
                end
            endcase
        end
    end

    // LED source follows the next state so led and mode move together
    always_comb begin
        w_led_mux = c_LED_ALL_OFF;
        case (w_next_state)
            c_ST_CYLON: w_led_mux = cylon_q;
            c_ST_ERR:   w_led_mux = w_next_phase ? c_LED_ALL_ON : c_LED_ALL_OFF;
            c_ST_STAT:  w_led_mux = w_next_stat;
            default:    w_led_mux = c_LED_ALL_OFF;
        endcase
    end

    // State, counters, pending error and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_ST_CYLON;
            r_err_pend  <= 1'b0;
            r_phase     <= 1'b0;
            r_flash_cnt <= '0;
            r_hold_cnt  <= '0;
            r_stat_reg  <= '0;
            r_led       <= c_LED_ALL_OFF;
            r_stat_ack  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_phase     <= w_next_phase;
            r_flash_cnt <= w_next_flash;
            r_hold_cnt  <= w_next_hold;
            r_stat_reg  <= w_next_stat;
            r_led       <= w_led_mux;
            r_stat_ack  <= w_ack;
            // Requests inside ERR act as restarts, so the pending flag only
            // accumulates outside ERR and is dropped while disabled
            r_err_pend  <= cfg_enable && (w_next_state != c_ST_ERR)
                           && (r_err_pend || err_req);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_display_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_display_sched
//  Purpose  : Self-checking bench for led_display_sched with a cycle-count
//             reference model and directed scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_display_sched;

    localparam int MXPRE      = 3;
    localparam int FLASH_CNT  = 2;
    localparam int HOLD_TICKS = 3;
    localparam int c_TICK     = 1 << MXPRE;
    localparam int c_ERR_LEN  = 2 * FLASH_CNT * c_TICK;
    localparam int c_STAT_LEN = HOLD_TICKS * c_TICK;

    logic        clock = 1'b0;
    logic        reset;
    logic        cfg_enable;
    logic [1:0]  cfg_rate;
    logic [1:0]  cylon_rate;
    logic [11:0] cylon_q;
    logic        err_req;
    logic        stat_req;
    logic [11:0] stat_data;
    logic        stat_ack;
    logic [11:0] led;
    logic [1:0]  mode;

    int n_tests = 0;
    int n_fail  = 0;
    bit run_cmp = 1'b0;

    led_display_sched #(
        .MXPRE      (MXPRE),
        .FLASH_CNT  (FLASH_CNT),
        .HOLD_TICKS (HOLD_TICKS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cfg_enable (cfg_enable),
        .cfg_rate   (cfg_rate),
        .cylon_rate (cylon_rate),
        .cylon_q    (cylon_q),
        .err_req    (err_req),
        .stat_req   (stat_req),
        .stat_data  (stat_data),
        .stat_ack   (stat_ack),
        .led        (led),
        .mode       (mode)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: who owns the display and for how many cycles
    int          m_mode = 0;
    int          m_el   = 0;
    bit          m_pend = 0;
    bit          m_ack  = 0;
    logic [11:0] m_led  = '0;
    logic [11:0] m_stat = '0;

    always @(posedge clock) begin
        int nm;
        if (reset) begin
            m_mode = 0; m_el = 0; m_pend = 0; m_ack = 0; m_led = '0; m_stat = '0;
        end else begin
            nm = m_mode;
            m_ack = 0;
            if (!cfg_enable) nm = 3;
            else begin
                case (m_mode)
                    3: nm = 0;
                    0: if (m_pend) begin nm = 1; m_el = 0; end
                       else if (stat_req && !err_req) begin
                           nm = 2; m_el = 0; m_stat = stat_data; m_ack = 1;
                       end
                    2: if (m_pend) begin nm = 1; m_el = 0; end
                       else begin m_el++; if (m_el == c_STAT_LEN) nm = 0; end
                    default: if (err_req) m_el = 0;
                             else begin m_el++; if (m_el == c_ERR_LEN) nm = 0; end
                endcase
            end
            m_pend = cfg_enable && (nm != 1) && (m_pend || err_req);
            m_mode = nm;
            case (nm)
                0: m_led = cylon_q;
                1: m_led = (((m_el / c_TICK) % 2) == 0) ? 12'hFFF : 12'h000;
                2: m_led = m_stat;
                default: m_led = 12'h000;
            endcase
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        if (run_cmp) begin
            chk("model_led", led, m_led);
            chk("model_mode", {10'd0, mode}, 12'(m_mode));
            chk("model_ack", {11'd0, stat_ack}, {11'd0, m_ack});
            chk("model_rate", {10'd0, cylon_rate}, {10'd0, cfg_rate});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; cfg_enable = 1'b0; cfg_rate = 2'd0; cylon_q = '0;
        err_req = 1'b0; stat_req = 1'b0; stat_data = '0;
        cyc(3);
        run_cmp = 1'b1;
        chk("reset_led", led, 12'h000);
        chk("reset_mode", {10'd0, mode}, 12'd0);
        chk("reset_ack", {11'd0, stat_ack}, 12'd0);

        // 1: cylon pass-through
        reset = 1'b0; cfg_enable = 1'b1; cylon_q = 12'h001; cfg_rate = 2'd2;
        cyc(1);
        chk("t1_led", led, 12'h001);
        chk("t1_mode", {10'd0, mode}, 12'd0);
        chk("t1_rate", {10'd0, cylon_rate}, 12'd2);
        cylon_q = 12'h002;
        cyc(3);

        // 2: single error pulse, 32-cycle flash
        err_req = 1'b1; cyc(1); err_req = 1'b0;
        chk("t2_pend_mode", {10'd0, mode}, 12'd0);
        cyc(1);
        chk("t2_e0_led", led, 12'hFFF);
        chk("t2_e0_mode", {10'd0, mode}, 12'd1);
        cylon_q = 12'h004;
        cyc(7);  chk("t2_e7_led", led, 12'hFFF);
        cyc(1);  chk("t2_e8_led", led, 12'h000);
        cyc(8);  chk("t2_e16_led", led, 12'hFFF);
        cyc(15); chk("t2_e31_mode", {10'd0, mode}, 12'd1);
        chk("t2_e31_led", led, 12'h000);
        cyc(1);  chk("t2_e32_mode", {10'd0, mode}, 12'd0);
        chk("t2_e32_led", led, 12'h004);
        cyc(2);

        // 3: status request held until acked
        stat_req = 1'b1; stat_data = 12'hA5C;
        cyc(1);
        chk("t3_ack", {11'd0, stat_ack}, 12'd1);
        chk("t3_led", led, 12'hA5C);
        chk("t3_mode", {10'd0, mode}, 12'd2);
        stat_req = 1'b0; stat_data = 12'h111;
        cyc(1);  chk("t3_ack_drop", {11'd0, stat_ack}, 12'd0);
        chk("t3_hold_led", led, 12'hA5C);
        cyc(22); chk("t3_s23_mode", {10'd0, mode}, 12'd2);
        cyc(1);  chk("t3_s24_mode", {10'd0, mode}, 12'd0);
        chk("t3_s24_led", led, 12'h004);
        cyc(2);

        // 4: error preempts status; status re-acked afterwards
        stat_req = 1'b1; stat_data = 12'h3C3;
        cyc(1);  chk("t4_ack1", {11'd0, stat_ack}, 12'd1);
        cyc(10); err_req = 1'b1;
        cyc(1);  err_req = 1'b0; stat_data = 12'h5A5;
        cyc(1);  chk("t4_err_mode", {10'd0, mode}, 12'd1);
        chk("t4_err_led", led, 12'hFFF);
        cyc(31); chk("t4_err_end_mode", {10'd0, mode}, 12'd1);
        cyc(1);  chk("t4_cylon_mode", {10'd0, mode}, 12'd0);
        chk("t4_cylon_ack", {11'd0, stat_ack}, 12'd0);
        cyc(1);  chk("t4_ack2", {11'd0, stat_ack}, 12'd1);
        chk("t4_led2", led, 12'h5A5);
        stat_req = 1'b0;
        cyc(30);

        // 5: disable mid-error clears the pending flash
        err_req = 1'b1; cyc(1); err_req = 1'b0;
        cyc(6);  chk("t5_in_err", {10'd0, mode}, 12'd1);
        cfg_enable = 1'b0;
        cyc(1);  chk("t5_off_led", led, 12'h000);
        chk("t5_off_mode", {10'd0, mode}, 12'd3);
        cyc(3);  cfg_enable = 1'b1;
        cyc(1);  chk("t5_on_mode", {10'd0, mode}, 12'd0);
        chk("t5_on_led", led, 12'h004);
        cyc(20); chk("t5_no_flash", {10'd0, mode}, 12'd0);

        // 6: restart during third phase
        err_req = 1'b1; cyc(1); err_req = 1'b0;
        cyc(1);  chk("t6_entry", {10'd0, mode}, 12'd1);
        cyc(17); chk("t6_phase3_led", led, 12'hFFF);
        err_req = 1'b1;
        cyc(1);  err_req = 1'b0;
        chk("t6_restart_led", led, 12'hFFF);
        cyc(8);  chk("t6_r8_led", led, 12'h000);
        cyc(23); chk("t6_r31_mode", {10'd0, mode}, 12'd1);
        cyc(1);  chk("t6_r32_mode", {10'd0, mode}, 12'd0);
        cyc(2);

        // 6b: simultaneous error and status request
        err_req = 1'b1; stat_req = 1'b1; stat_data = 12'h777;
        cyc(1);  err_req = 1'b0;
        chk("t6b_no_ack", {11'd0, stat_ack}, 12'd0);
        chk("t6b_mode0", {10'd0, mode}, 12'd0);
        cyc(1);  chk("t6b_err", {10'd0, mode}, 12'd1);
        cyc(32); chk("t6b_back", {10'd0, mode}, 12'd0);
        chk("t6b_still_no_ack", {11'd0, stat_ack}, 12'd0);
        cyc(1);  chk("t6b_ack", {11'd0, stat_ack}, 12'd1);
        chk("t6b_led", led, 12'h777);
        stat_req = 1'b0;
        cyc(30);

        run_cmp = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_display_sched.md
# led_display_sched

Scheduler that shares the 12-LED front-panel display between three sources: the free-running cylon pattern generator (idle), an error-flash sequence, and a timed status-word display. It sits between the cylon generator's `q` output and the LED pins, forwards the configured scan rate to the generator, and resolves source priority on every cycle. Priority is OFF > error > status > cylon.

## Interface
Parameters:
- `MXPRE`, 21: tick prescaler width. One tick lasts 2^MXPRE clocks.
- `FLASH_CNT`, 4: number of on/off flash pairs in one error sequence.
- `HOLD_TICKS`, 8: number of ticks the status word is held on the display.

Ports:
- `clock`  in  1: the single clock.
- `reset`  in  1: reset, synchronous and active-high.
- `cfg_enable`  in  1: display enable. When 0, the block forces state OFF.
- `cfg_rate`  in  2: cylon scan rate.
- `cylon_rate`  out  2: combinational copy of `cfg_rate`, driven to the cylon generator.
- `cylon_q`  in  12: pattern from the cylon generator.
- `err_req`  in  1: error pulse, latched into `err_pend`.
- `stat_req`  in  1: status request. Level, held until `stat_ack`.
- `stat_data`  in  12: status word, captured on `stat_ack`.
- `stat_ack`  out  1: one-cycle pulse, registered.
- `led`  out  12: LED drive, registered.
- `mode`  out  2: current state, registered. CYLON=0, ERR=1, STAT=2, OFF=3.

## Operation
**Reset values.** `reset` forces:
- state CYLON
- `led`=0, `stat_ack`=0, `mode`=0
- `err_pend`=0, prescaler=0, `flash_cnt`=0, `hold_cnt`=0, `stat_reg`=0, `phase`=0

`err_req` is ignored while `reset` is high.

**Tick.**
- The prescaler increments every cycle.
- `tick` is asserted when the prescaler is all ones.
- The prescaler clears to 0 on every state transition, so the first tick after a state entry arrives exactly 2^MXPRE cycles later.

**`err_pend`.**
- Set by `err_req`.
- Cleared on entry to ERR.
- Cleared, and held clear, while `cfg_enable`=0.

**Per-cycle transition rule.** Checked in this order:
1. If `cfg_enable`=0, go to OFF.
2. In OFF with `cfg_enable`=1, go to CYLON.
3. In CYLON or STAT with `err_pend`=1, go to ERR. This preempts STAT; the status display is abandoned.
4. In CYLON with `stat_req`=1, go to STAT: capture `stat_data` into `stat_reg` and pulse `stat_ack`.
5. In ERR, on each `tick`: toggle `phase`, increment `flash_cnt`. When `flash_cnt` reaches 2*FLASH_CNT-1, go to CYLON.
6. In STAT, on each `tick`: increment `hold_cnt`. When `hold_cnt` reaches HOLD_TICKS-1, go to CYLON.

**ERR behaviour.**
- Entry sets `phase`=1 and `flash_cnt`=0.
- `err_req` while in ERR restarts the sequence: `flash_cnt`=0, `phase`=1, prescaler cleared.

**STAT behaviour.**
- Entry sets `hold_cnt`=0.
- `stat_req` is never acked outside CYLON. A requester holding `stat_req` high is acked on the first CYLON cycle with no error pending.

**LED mux.** The mux input is the next state, so `led` and `mode` change on the same edge as the state:
- CYLON: `cylon_q`
- ERR: all ones when `phase`=1, otherwise 0
- STAT: `stat_reg`
- OFF: 0

**Counter widths.**
- `flash_cnt` is $clog2(2*FLASH_CNT) bits. `hold_cnt` is $clog2(HOLD_TICKS) bits.
- Neither counter wraps; each exits at its terminal value.

## Timing
- `err_req` sampled high at edge k: `err_pend`=1 after edge k. Then at edge k+1, the state becomes ERR, `mode`=1 and `led`=12'hFFF.
- `stat_req` high in CYLON at edge k: after edge k, the state is STAT, `stat_ack`=1 for exactly one cycle, and `led` shows `stat_data` as sampled at edge k.
- ERR lasts 2*FLASH_CNT*2^MXPRE cycles. STAT lasts HOLD_TICKS*2^MXPRE cycles.
- `cfg_enable` falling at edge k: `led`=0 and `mode`=3 after edge k.
- `cylon_q` is passed through to `led` with 1 cycle of latency.

## Structure
- Shared package/include:
  - state encodings CYLON/ERR/STAT/OFF
  - LED_ALL_ON = 12'hFFF, LED_ALL_OFF = 12'h000
- Sub-module `led_tick`: prescaler of width MXPRE with a synchronous `clear` input and a `tick` output. It is reusable by other panel blocks.

## Test plan
All scenarios use MXPRE=3, FLASH_CNT=2, HOLD_TICKS=3, so one tick = 8 cycles.

1. Reset, then `cfg_enable`=1, `cylon_q`=12'h001, `cfg_rate`=2 -> `led`=12'h001 one cycle later, `mode`=0, `cylon_rate`=2.
2. Single-cycle `err_req` -> `led` shows FFF(8 cycles), 000(8), FFF(8), 000(8), then `cylon_q`; `mode`=1 throughout, exactly 32 cycles.
3. `stat_req` held with `stat_data`=12'hA5C -> one `stat_ack` pulse, `led`=12'hA5C for 24 cycles, `mode`=2, then `cylon_q`.
4. `err_req` 10 cycles into STAT, with `stat_req` still high -> ERR for 32 cycles, then CYLON, then `stat_req` re-acked with new `stat_data`.
5. `cfg_enable`=0 mid-ERR -> `led`=0, `mode`=3 next cycle. On re-enable: `mode`=0 with no flash, because `err_pend` was cleared.
6. `err_req` during the third phase of ERR -> sequence restarts with `led`=FFF; ERR ends 32 cycles after the restart. Also: `err_req` and `stat_req` asserted in the same cycle -> ERR first, no `stat_ack` until ERR completes.
